// File: rtl/req_ack_responder.sv
// req_ack_responder
//   Detects request rises on a level `req` line, acknowledges each accepted
//   request with a one-cycle `ack` pulse, buffers {payload, sequence tag} and
//   delivers them oldest-first on a valid/ready response port.
//
// Ports
//   clk       in   clock, all state on posedge
//   rst       in   synchronous active-high reset
//   start     in   arm pulse (first high sample arms, later ones ignored)
//   req       in   request level; each 0->1 transition is one request
//   req_data  in   request payload, sampled on the rise edge
//   ready     in   initiator accepts response when high with valid
//   ack       out  one-cycle acceptance pulse
//   valid     out  response available
//   rsp_data  out  payload of oldest accepted request
//   rsp_tag   out  acceptance sequence number (mod 256)
//   pending   out  accepted requests not yet delivered (0..DEPTH)
//   armed     out  responder armed
//   overflow  out  sticky: a request was dropped because the buffer was full
module req_ack_responder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       req,
    input  logic [DATA_W-1:0]          req_data,
    input  logic                       ready,
    output logic                       ack,
    output logic                       valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [7:0]                 rsp_tag,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       armed,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        S_DISARMED,
        S_IDLE,
        S_BUSY
    } state_t;

    state_t state, state_n;

    logic              req_q;
    logic [7:0]        tag;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [PW-1:0]     fcount;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [7:0]        mem_tag  [DEPTH];

    logic rise, has_room, push, drop, pop, load;

    // pending counts buffered entries plus the one held in the output
    // register, so the full check covers the whole pipeline.
    always_comb begin
        rise     = (state != S_DISARMED) && req && !req_q;
        has_room = pending < PW'(DEPTH);
        push     = rise && has_room;
        drop     = rise && !has_room;
        pop      = valid && ready;
        // Reload the output register whenever it is empty or being popped,
        // which gives back-to-back delivery without a bubble.
        load     = (fcount != '0) && (!valid || ready);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_DISARMED: if (start) state_n = S_IDLE;
            S_IDLE:     if (push)  state_n = S_BUSY;
            S_BUSY:     if (pop && !push && pending == PW'(1)) state_n = S_IDLE;
            default:    state_n = S_DISARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_DISARMED;
            armed    <= 1'b0;
            req_q    <= 1'b0;
            tag      <= '0;
            ack      <= 1'b0;
            overflow <= 1'b0;
            pending  <= '0;
        end else begin
            state    <= state_n;
            armed    <= (state_n != S_DISARMED);
            req_q    <= req;
            ack      <= push;
            overflow <= overflow | drop;
            if (push) tag <= tag + 8'd1;
            case ({push, pop})
                2'b10:   pending <= pending + PW'(1);
                2'b01:   pending <= pending - PW'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            case ({push, load})
                2'b10:   fcount <= fcount + PW'(1);
                2'b01:   fcount <= fcount - PW'(1);
                default: fcount <= fcount;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= req_data;
            mem_tag[wr_ptr]  <= tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            rsp_data <= '0;
            rsp_tag  <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            rsp_data <= mem_data[rd_ptr];
            rsp_tag  <= mem_tag[rd_ptr];
        end else if (pop) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_req_ack_responder.sv
module tb_req_ack_responder;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst, start, req, ready;
    logic [DATA_W-1:0] req_data;
    logic              ack, valid, armed, overflow;
    logic [DATA_W-1:0] rsp_data;
    logic [7:0]        rsp_tag;
    logic [$clog2(DEPTH):0] pending;

    int unsigned total = 0;
    int unsigned bad   = 0;

    req_ack_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .req(req), .req_data(req_data),
        .ready(ready), .ack(ack), .valid(valid), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .pending(pending), .armed(armed), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; req = 1'b0; ready = 1'b0; req_data = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_armed"},    32'(armed),    32'd0);
        chk({name, "_ack"},      32'(ack),      32'd0);
        chk({name, "_valid"},    32'(valid),    32'd0);
        chk({name, "_pending"},  32'(pending),  32'd0);
        chk({name, "_overflow"}, 32'(overflow), 32'd0);
        chk({name, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({name, "_rsp_tag"},  32'(rsp_tag),  32'd0);
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One request: rise for one cycle, then drop; returns ack seen after rise edge.
    task automatic pulse_req(input logic [DATA_W-1:0] d, output logic ack_seen);
        req = 1'b1; req_data = d;
        tick();
        ack_seen = ack;
        req = 1'b0;
        tick();
    endtask

    logic a;

    initial begin
        // ---------------- basic single transfer ----------------
        do_reset();
        check_reset_state("rst0");
        arm();
        chk("arm_armed", 32'(armed), 32'd1);
        ready = 1'b1;
        req = 1'b1; req_data = 8'h5A;
        tick();
        chk("t1_ack",     32'(ack),     32'd1);
        chk("t1_valid0",  32'(valid),   32'd0);
        chk("t1_pending", 32'(pending), 32'd1);
        req = 1'b0;
        tick();
        chk("t1_ack_off", 32'(ack),      32'd0);
        chk("t1_valid",   32'(valid),    32'd1);
        chk("t1_data",    32'(rsp_data), 32'h5A);
        chk("t1_tag",     32'(rsp_tag),  32'd0);
        tick();
        chk("t1_valid_off", 32'(valid),   32'd0);
        chk("t1_pend0",     32'(pending), 32'd0);

        // ---------------- rises while disarmed ----------------
        do_reset();
        ready = 1'b1;
        pulse_req(8'h33, a);
        chk("dis_ack1", 32'(a), 32'd0);
        pulse_req(8'h44, a);
        chk("dis_ack2",  32'(a),        32'd0);
        chk("dis_valid", 32'(valid),    32'd0);
        chk("dis_ovf",   32'(overflow), 32'd0);
        chk("dis_pend",  32'(pending),  32'd0);
        arm();
        pulse_req(8'h11, a);
        chk("dis_arm_ack", 32'(a),        32'd1);
        chk("dis_valid1",  32'(valid),    32'd1);
        chk("dis_data",    32'(rsp_data), 32'h11);
        chk("dis_tag",     32'(rsp_tag),  32'd0);

        // ---------------- overflow with stalled consumer ----------------
        do_reset();
        arm();
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            pulse_req(DATA_W'(i), a);
            chk($sformatf("ovf_ack%0d", i), 32'(a), (i <= 4) ? 32'd1 : 32'd0);
        end
        chk("ovf_pending", 32'(pending),  32'd4);
        chk("ovf_flag",    32'(overflow), 32'd1);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_valid%0d", k), 32'(valid),    32'd1);
            chk($sformatf("drain_data%0d", k),  32'(rsp_data), 32'(k + 1));
            chk($sformatf("drain_tag%0d", k),   32'(rsp_tag),  32'(k));
            chk($sformatf("drain_pend%0d", k),  32'(pending),  32'(4 - k));
            tick();
        end
        chk("drain_valid_end", 32'(valid),    32'd0);
        chk("drain_pend_end",  32'(pending),  32'd0);
        chk("drain_ovf_stick", 32'(overflow), 32'd1);

        // ---------------- stall hold + simultaneous push/pop ----------------
        do_reset();
        check_reset_state("rst_ovf");
        arm();
        ready = 1'b0;
        pulse_req(8'hA0, a);
        chk("st_valid", 32'(valid), 32'd1);
        req = 1'b1; req_data = 8'hB1;
        tick();
        chk("st1_data", 32'(rsp_data), 32'hA0);
        chk("st1_tag",  32'(rsp_tag),  32'd0);
        req = 1'b0;
        tick();
        chk("st2_data", 32'(rsp_data), 32'hA0);
        chk("st2_pend", 32'(pending),  32'd2);
        tick();
        chk("st3_data", 32'(rsp_data), 32'hA0);
        chk("st3_tag",  32'(rsp_tag),  32'd0);
        chk("st3_pend", 32'(pending),  32'd2);
        ready = 1'b1; req = 1'b1; req_data = 8'hC2;
        tick();
        chk("pp_pend", 32'(pending),  32'd2);
        chk("pp_ack",  32'(ack),      32'd1);
        chk("pp_data", 32'(rsp_data), 32'hB1);
        chk("pp_tag",  32'(rsp_tag),  32'd1);
        req = 1'b0;
        tick();
        chk("pp2_data", 32'(rsp_data), 32'hC2);
        chk("pp2_tag",  32'(rsp_tag),  32'd2);
        chk("pp2_pend", 32'(pending),  32'd1);
        tick();
        chk("pp3_valid", 32'(valid),   32'd0);
        chk("pp3_pend",  32'(pending), 32'd0);

        // ---------------- reset mid-stall ----------------
        do_reset();
        arm();
        ready = 1'b0;
        pulse_req(8'h01, a);
        pulse_req(8'h02, a);
        pulse_req(8'h03, a);
        chk("ms_pend",  32'(pending), 32'd3);
        chk("ms_valid", 32'(valid),   32'd1);
        rst = 1'b1; ready = 1'b1;
        tick();
        rst = 1'b0; ready = 1'b0;
        check_reset_state("ms_rst");
        arm();
        pulse_req(8'h77, a);
        chk("ms_ack",  32'(a),        32'd1);
        chk("ms_data", 32'(rsp_data), 32'h77);
        chk("ms_tag",  32'(rsp_tag),  32'd0);

        // ---------------- req held high across reset release ----------------
        do_reset();
        req = 1'b1;
        tick();
        arm();
        tick();
        chk("hold_ack",  32'(ack),     32'd0);
        chk("hold_pend", 32'(pending), 32'd0);
        req = 1'b0;
        tick();
        req = 1'b1; req_data = 8'h99;
        tick();
        chk("hold_rise_ack", 32'(ack), 32'd1);
        tick();
        chk("hold_no_reack", 32'(ack), 32'd0);
        req = 1'b0;

        // ---------------- tag wrap over 257 requests ----------------
        do_reset();
        arm();
        ready = 1'b1;
        for (int n = 0; n < 257; n++) begin
            pulse_req(DATA_W'(n), a);
            if (n >= 253) begin
                chk($sformatf("wrap_ack%0d", n),  32'(a),        32'd1);
                chk($sformatf("wrap_tag%0d", n),  32'(rsp_tag),  32'(n % 256));
                chk($sformatf("wrap_data%0d", n), 32'(rsp_data), 32'(n % 256));
            end
            tick();
        end
        ready = 1'b1;
        pulse_req(8'hEE, a);
        chk("wrap_tag_again", 32'(rsp_tag),  32'd1);
        chk("wrap_ovf",       32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/req_ack_responder.md
REQ_ACK_RESPONDER -- requirements
Module: req_ack_responder

Interface
REQ-001 Parameter DATA_W, default 8, width of request/response data.
REQ-002 Parameter DEPTH, default 4, pending-request buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  arm pulse; first sample high arms the responder.
REQ-006 req  input  1  initiator request level; a 0->1 transition is one request.
REQ-007 req_data  input  DATA_W  request payload, sampled on the edge where the request rise is detected.
REQ-008 ready  input  1  initiator accepts the response when high with valid.
REQ-009 ack  output  1  one-cycle acceptance pulse.
REQ-010 valid  output  1  response available.
REQ-011 rsp_data  output  DATA_W  payload of the oldest accepted request.
REQ-012 rsp_tag  output  8  acceptance sequence number of the response, mod 256.
REQ-013 pending  output  $clog2(DEPTH)+1  accepted requests not yet delivered.
REQ-014 armed  output  1  responder armed.
REQ-015 overflow  output  1  sticky flag: a request was dropped.

Function
REQ-016 Rise detection: rise at edge t iff armed, req=1 at t, and req=0 at t-1; the req history register is updated every cycle, armed or not.
REQ-017 Disarmed: rises are ignored; no ack, no push, no overflow.
REQ-018 Arming: start=1 at edge t sets armed from t+1; rises are counted from edge t+1; further start pulses have no effect.
REQ-019 Acceptance: a rise at t with fewer than DEPTH entries stored (evaluated before any pop at t) pushes {req_data, tag} and drives ack=1 for exactly the cycle after t.
REQ-020 The tag counter starts at 0, increments by 1 per accepted request, and wraps 255->0.
REQ-021 Full: a rise with DEPTH entries stored produces no ack and no push, sets overflow, and leaves the tag unchanged.
REQ-022 Latency: valid rises no earlier than 2 cycles after the rise edge, so rise@t, ack sampled @t+1, valid sampled @t+2 holds whenever the buffer was empty and no response was stalled at t.
REQ-023 Response: valid=1 whenever an entry is visible; rsp_data and rsp_tag show the oldest entry and stay stable while valid=1 and ready=0.
REQ-024 Pop: valid=1 and ready=1 at an edge pops the oldest entry; the next entry becomes visible the following cycle without a bubble.
REQ-025 Simultaneous push and pop: pending is unchanged, and the full check uses the pre-pop count.
REQ-026 pending = pushes minus pops, range 0..DEPTH; it updates one cycle after the push or pop edge.
REQ-027 FSM states, with transitions on clock edges:
  - DISARMED -> IDLE on start.
  - IDLE -> BUSY on the first push.
  - BUSY -> IDLE when the last entry pops and no push occurs on that edge.
REQ-028 The FSM state drives armed (0 only in DISARMED) and qualifies rise detection.
REQ-029 A request whose rise coincides with its acceptance (req pulsed for a single cycle) is accepted exactly once.
REQ-030 Holding req high generates no further requests; a new request needs req to return to 0 for at least one sampled cycle.
REQ-031 All outputs are registered.

Reset
REQ-032 rst=1 at an edge forces the following on the next cycle, overriding all other inputs, including mid-transfer and mid-stall:
  - state DISARMED, armed=0;
  - ack=0, valid=0, pending=0, overflow=0;
  - rsp_data=0, rsp_tag=0;
  - tag counter 0, buffer emptied, req history 0.
REQ-033 After reset release, a req already high counts as a rise once armed only if req was sampled 0 after release.

Verification
REQ-034 Reset, start pulse, req rise with req_data=0x5A, ready=1 -> ack=1 one cycle later, then valid=1 with rsp_data=0x5A and rsp_tag=0 one cycle after ack, then valid=0.
REQ-035 Req rises before any start pulse -> ack, valid and overflow stay 0; after start, a rise with req_data=0x11 -> tag 0 and data 0x11 delivered.
REQ-036 Armed, ready=0, DEPTH+1 rises with data 1..5 -> four acks, pending=4, overflow=1, no ack on the fifth; then ready=1 -> data 1,2,3,4 with tags 0..3 on consecutive cycles, pending reaches 0.
REQ-037 Stall on entry tag 0 with ready=0 for 3 cycles while one new rise arrives -> rsp_data and rsp_tag are held, pending=2; with ready=1, push and pop on the same edge -> pending unchanged.
REQ-038 Mid-stall with pending=3, assert rst for 1 cycle -> all outputs at reset values next cycle; a fresh start and one rise -> tag 0 again.
REQ-039 Accept 257 requests, draining each -> rsp_tag wraps from 255 to 0 and then to 1, and overflow stays 0.
